// File: rtl/hazard_scoreboard_if.sv
// Decode-stage bundle between the D stage and the hazard scoreboard.
// master: decode stage (drives the instruction fields, sees stall/md_busy).
// slave:  scoreboard (reads the instruction fields, drives stall/md_busy).
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int TW = 2
);
    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic          d_rs_use;
    logic [TW-1:0] d_rs_tuse;
    logic [AW-1:0] d_rt;
    logic          d_rt_use;
    logic [TW-1:0] d_rt_tuse;
    logic          d_wr_en;
    logic [AW-1:0] d_wr_addr;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_md_use;
    logic          stall;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rs_use, d_rs_tuse, d_rt, d_rt_use, d_rt_tuse,
               d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rs_use, d_rs_tuse, d_rt, d_rt_use, d_rt_tuse,
               d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall unit for the 5-stage MIPS pipeline.
// Each GPR carries a Tnew countdown loaded at issue; decode stalls when a
// source is needed (Tuse) before its producer can forward (remaining Tnew).
// A private HI/LO busy counter covers mult/div latency.
// Optional feature: define HAZARD_STATS_EN to build the saturating stall-cycle
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int MDW      = 4
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  dec,
    output logic [31:0]         stall_cnt
);

    // Array spans the full address space; entries 0 and >= NREG stay zero,
    // so any rs/rt address can index it directly.
    logic [TW-1:0]  cnt [2**AW];
    logic [TW-1:0]  rs_cnt;
    logic [TW-1:0]  rt_cnt;
    logic           hz_rs;
    logic           hz_rt;
    logic           hz_md;
    logic           issue;
    logic [MDW-1:0] md_cnt;
    logic [MDW-1:0] md_cnt_nxt;

    // Hazard detection against the pre-update scoreboard.
    always_comb begin
        rs_cnt    = cnt[dec.d_rs];
        rt_cnt    = cnt[dec.d_rt];
        hz_rs     = dec.d_rs_use && (dec.d_rs != '0) && (rs_cnt > dec.d_rs_tuse);
        hz_rt     = dec.d_rt_use && (dec.d_rt != '0) && (rt_cnt > dec.d_rt_tuse);
        hz_md     = dec.d_md_use && (md_cnt != '0);
        dec.stall = dec.d_valid && (hz_rs || hz_rt || hz_md);
        issue     = dec.d_valid && !dec.stall;
    end

    // Next HI/LO busy count: saturating decrement, a new mult/div load wins.
    always_comb begin
        md_cnt_nxt = md_cnt;
        if (md_cnt != '0)
            md_cnt_nxt = md_cnt - 1'b1;
        if (issue && dec.d_md_start)
            md_cnt_nxt = dec.d_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
    end

    // Per-register Tnew countdown; decrement keeps running during stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 2**AW; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 2**AW; r++) begin
                if (r == 0 || r >= NREG)
                    cnt[r] <= '0;
                else if (issue && dec.d_wr_en && dec.d_wr_addr == AW'(r))
                    cnt[r] <= dec.d_tnew;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // HI/LO counter and its registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt      <= '0;
            dec.md_busy <= 1'b0;
        end else begin
            md_cnt      <= md_cnt_nxt;
            dec.md_busy <= (md_cnt_nxt != '0);
        end
    end

`ifdef HAZARD_STATS_EN
    // Stall-cycle counter, saturating, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (dec.stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
